// File: rtl/mult_arbiter_pkg.sv
// Shared types and constants for the two-requester multiplier arbiter.
// Holds the sequencer state encoding, requester-ID width and default watchdog limit.
package mult_arbiter_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StBusy  = 2'd1,
        StResp  = 2'd2,
        StDrain = 2'd3
    } state_e;

    localparam int unsigned IdWidth        = 1;
    localparam int unsigned DefaultTimeout = 64;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-port round-robin arbiter: a lone requester always wins, a tie goes to the
// port not granted last. last_grant only moves when update is asserted.
module rr_arbiter2
    import mult_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       update,
    output logic [1:0] grant
);

    logic last_grant_q;
    logic last_grant_d;

    always_comb begin
        grant = 2'b00;
        unique case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_grant_q ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

    always_comb begin
        last_grant_d = last_grant_q;
        if (update && (grant != 2'b00)) begin
            last_grant_d = grant[1];
        end
    end

    // Reset to 1 so requester 0 takes the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_q <= 1'b1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/mult_arbiter.sv
// Shares one sequential 8x8 multiplier between two requesters: grants a job,
// holds start/operands for its duration, returns product and ID, and aborts hung jobs.
module mult_arbiter
    import mult_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DefaultTimeout
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        req0_valid,
    input  logic [7:0]  req0_a,
    input  logic [7:0]  req0_b,
    output logic        req0_ready,

    input  logic        req1_valid,
    input  logic [7:0]  req1_a,
    input  logic [7:0]  req1_b,
    output logic        req1_ready,

    output logic        mul_start,
    output logic [7:0]  mul_a,
    output logic [7:0]  mul_b,
    input  logic        mul_done,
    input  logic [15:0] mul_result,

    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_data,
    output logic        rsp_id,
    output logic        rsp_err,

    output logic        busy
);

    localparam int unsigned WdWidth = $clog2(TIMEOUT_CYCLES);
    localparam logic [WdWidth-1:0] WdLast = WdWidth'(TIMEOUT_CYCLES - 1);
    localparam logic [WdWidth-1:0] WdMax  = {WdWidth{1'b1}};

    state_e               state_q, state_d;
    logic [7:0]           mul_a_q, mul_a_d;
    logic [7:0]           mul_b_q, mul_b_d;
    logic [15:0]          rsp_data_q, rsp_data_d;
    logic [IdWidth-1:0]   rsp_id_q, rsp_id_d;
    logic                 rsp_err_q, rsp_err_d;
    logic [WdWidth-1:0]   wd_q, wd_d;

    logic [1:0] req_vec;
    logic [1:0] grant;
    logic       arb_update;

    assign req_vec    = {req1_valid, req0_valid};
    assign arb_update = (state_q == StIdle);

    rr_arbiter2 u_rr_arbiter2 (
        .clk    (clk),
        .rst    (rst),
        .req    (req_vec),
        .update (arb_update),
        .grant  (grant)
    );

    // Ready is only offered from IDLE, so a grant is a single-cycle pulse.
    assign req0_ready = (state_q == StIdle) && grant[0];
    assign req1_ready = (state_q == StIdle) && grant[1];

    assign mul_start = (state_q == StBusy);
    assign rsp_valid = (state_q == StResp);
    assign busy      = (state_q != StIdle);
    assign mul_a     = mul_a_q;
    assign mul_b     = mul_b_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_err   = rsp_err_q;

    always_comb begin
        state_d    = state_q;
        mul_a_d    = mul_a_q;
        mul_b_d    = mul_b_q;
        rsp_data_d = rsp_data_q;
        rsp_id_d   = rsp_id_q;
        rsp_err_d  = rsp_err_q;
        wd_d       = wd_q;

        unique case (state_q)
            StIdle: begin
                if (grant != 2'b00) begin
                    mul_a_d  = grant[1] ? req1_a : req0_a;
                    mul_b_d  = grant[1] ? req1_b : req0_b;
                    rsp_id_d = grant[1];
                    wd_d     = '0;
                    state_d  = StBusy;
                end
            end
            StBusy: begin
                wd_d = (wd_q == WdMax) ? wd_q : wd_q + 1'b1;
                // Completion beats a simultaneous timeout.
                if (mul_done) begin
                    rsp_data_d = mul_result;
                    rsp_err_d  = 1'b0;
                    state_d    = StResp;
                end else if (wd_q == WdLast) begin
                    rsp_data_d = 16'h0000;
                    rsp_err_d  = 1'b1;
                    state_d    = StResp;
                end
            end
            StResp: begin
                if (rsp_ready) begin
                    state_d = mul_done ? StDrain : StIdle;
                end
            end
            StDrain: begin
                // Wait out a lingering done so it can't complete the next job.
                if (!mul_done) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            mul_a_q    <= 8'h00;
            mul_b_q    <= 8'h00;
            rsp_data_q <= 16'h0000;
            rsp_id_q   <= '0;
            rsp_err_q  <= 1'b0;
            wd_q       <= '0;
        end else begin
            state_q    <= state_d;
            mul_a_q    <= mul_a_d;
            mul_b_q    <= mul_b_d;
            rsp_data_q <= rsp_data_d;
            rsp_id_q   <= rsp_id_d;
            rsp_err_q  <= rsp_err_d;
            wd_q       <= wd_d;
        end
    end

endmodule
